fmul_arbiter: RTL and testbench
===============================

FMUL_ARBITER -- requirements
Module: fmul_arbiter

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the saturating overflow/underflow event counters.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have ports req0_valid and req1_valid, input, 1 each: requester 0/1 has an operand pair pending.
REQ-005 SHALL have ports req0_a, req0_b, req1_a and req1_b, input, 32 each: IEEE-754 single-precision operands per requester.
REQ-006 SHALL have ports req0_ready and req1_ready, output, 1 each: operand pair accepted this cycle.
REQ-007 SHALL have port res_valid, output, 1: result held on res_* outputs.
REQ-008 SHALL have port res_ready, input, 1: consumer accepts the result.
REQ-009 SHALL have port res_data, output, 32: product.
REQ-010 SHALL have ports res_overflow and res_underflow, output, 1 each: flags for res_data.
REQ-011 SHALL have port res_id, output, 1: requester index owning the result.
REQ-012 SHALL have ports fm_in1 and fm_in2, output, 32 each: operands to the shared combinational fmul.
REQ-013 SHALL have port fm_out, input, 32: fmul product.
REQ-014 SHALL have ports fm_overflow and fm_underflow, input, 1 each: fmul flags.
REQ-015 SHALL have ports ovf_cnt and unf_cnt, output, CNT_W each: saturating counts of results with the respective flag set.

Function
REQ-016 SHALL implement the FSM states IDLE, CALC and HOLD.
REQ-017 In IDLE with any reqN_valid, SHALL grant exactly one requester:
- Only one valid: grant that requester.
- Both valid: grant the requester not equal to last_grant (round-robin).
REQ-018 reqN_ready SHALL be combinational and high only in IDLE for the granted requester.
- Both readies SHALL never be high in the same cycle.
REQ-019 On the accept edge (IDLE, granted valid), SHALL:
- Capture the operands into op_a/op_b.
- Capture the index into the id register.
- Update last_grant.
- Go to CALC.
REQ-020 fm_in1/fm_in2 SHALL be driven from op_a/op_b registers only, never directly from requester inputs.
REQ-021 In CALC (one cycle), SHALL:
- Register fm_out, fm_overflow and fm_underflow into the result registers.
- Set res_valid.
- Go to HOLD.
REQ-022 Latency SHALL be 2 cycles: accept at edge N gives res_valid=1 after edge N+1 and visible in cycle N+2 until consumed.
REQ-023 In HOLD, res_data, res_overflow, res_underflow and res_id SHALL stay stable while res_valid=1 and res_ready=0.
REQ-024 In HOLD with res_ready=1, SHALL clear res_valid at that edge and go to IDLE.
- Result data registers keep their last values.
REQ-025 Minimum issue interval SHALL be 3 cycles (IDLE, CALC, HOLD).
- No new grant occurs in CALC or HOLD.
- Requesters hold valid and operands until ready.
REQ-026 A requester dropping valid before ready SHALL simply not be granted; there is no penalty and no state change.
REQ-027 res_ready asserted outside HOLD SHALL be ignored.
REQ-028 ovf_cnt SHALL increment on the CALC edge when fm_overflow=1, saturating at all-ones.
REQ-029 unf_cnt SHALL increment on the CALC edge when fm_underflow=1, saturating at all-ones.
- Both counters may increment on the same edge.
REQ-030 The block SHALL NOT interpret operand encodings; NaN/Inf/denormal handling belongs to fmul.

Reset
REQ-031 While rst_n=0 at a rising edge, SHALL force:
- state to IDLE.
- last_grant to 1, so requester 0 wins the first tie.
- res_valid, res_data, res_overflow, res_underflow, res_id, op_a, op_b, ovf_cnt and unf_cnt to 0.
REQ-032 Reset asserted in CALC or HOLD SHALL abort the operation.
- The in-flight result SHALL be discarded, never presented.
REQ-033 During reset, req0_ready and req1_ready SHALL be 0.

Verification
REQ-034 Single request, 3.0 x 2.0: req0 a=0x40400000, b=0x40000000, res_ready=1 -> res_valid 2 cycles after accept; res_data=0x40C00000; flags 0; res_id=0.
REQ-035 Contention and round-robin: both valid continuously from reset -> grant order 0,1,0,1; each ready pulse is 1 cycle; 3-cycle issue spacing.
REQ-036 Overflow: req1 a=b=0x7F7FFFFF -> res_overflow=1; res_id=1; ovf_cnt 0->1; unf_cnt unchanged.
REQ-037 Underflow: req0 a=0x00C00000, b=0x00400000 -> res_underflow=1; unf_cnt increments.
- Repeat 2^CNT_W+1 times -> unf_cnt saturates at all-ones.
REQ-038 Backpressure: res_ready=0 for 5 cycles -> res_* stable, no new ready; res_ready=1 -> res_valid falls next edge; next grant follows.
REQ-039 Reset mid-operation: rst_n=0 in CALC -> next cycle res_valid=0, state IDLE, counters 0, no result emitted.

Source files
------------

// File: rtl/fmul_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fmul_arbiter
//  Purpose  : Round-robin arbiter sharing one combinational fmul between two
//             requesters, with registered result hold and saturating
//             overflow/underflow event counters.
//  Revision : 1.0
// ============================================================================
module fmul_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    output logic             req1_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic             res_overflow,
    output logic             res_underflow,
    output logic             res_id,
    output logic [31:0]      fm_in1,
    output logic [31:0]      fm_in2,
    input  logic [31:0]      fm_out,
    input  logic             fm_overflow,
    input  logic             fm_underflow,
    output logic [CNT_W-1:0] ovf_cnt,
    output logic [CNT_W-1:0] unf_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [31:0]      op_a_q, op_a_d;
    logic [31:0]      op_b_q, op_b_d;
    logic             id_q, id_d;
    logic             res_valid_q, res_valid_d;
    logic [31:0]      res_data_q, res_data_d;
    logic             res_ovf_q, res_ovf_d;
    logic             res_unf_q, res_unf_d;
    logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
    logic [CNT_W-1:0] unf_cnt_q, unf_cnt_d;

    logic w_grant;
    logic w_accept;

    // On a tie the requester that did not win last time gets the grant.
    assign w_grant  = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    assign w_accept = (state_q == S_IDLE) && (req0_valid || req1_valid);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req0_valid || req1_valid) state_d = S_CALC;
            S_CALC:  state_d = S_HOLD;
            S_HOLD:  if (res_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (rst_n && (state_q == S_IDLE)) begin
            req0_ready = req0_valid && !w_grant;
            req1_ready = req1_valid &&  w_grant;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        id_d         = id_q;
        res_valid_d  = res_valid_q;
        res_data_d   = res_data_q;
        res_ovf_d    = res_ovf_q;
        res_unf_d    = res_unf_q;
        ovf_cnt_d    = ovf_cnt_q;
        unf_cnt_d    = unf_cnt_q;
        if (w_accept) begin
            last_grant_d = w_grant;
            id_d         = w_grant;
            op_a_d       = w_grant ? req1_a : req0_a;
            op_b_d       = w_grant ? req1_b : req0_b;
        end
        if (state_q == S_CALC) begin
            res_valid_d = 1'b1;
            res_data_d  = fm_out;
            res_ovf_d   = fm_overflow;
            res_unf_d   = fm_underflow;
            if (fm_overflow && (ovf_cnt_q != {CNT_W{1'b1}})) ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
            if (fm_underflow && (unf_cnt_q != {CNT_W{1'b1}})) unf_cnt_d = unf_cnt_q + CNT_W'(1);
        end
        if ((state_q == S_HOLD) && res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            op_a_q       <= 32'd0;
            op_b_q       <= 32'd0;
            id_q         <= 1'b0;
            res_valid_q  <= 1'b0;
            res_data_q   <= 32'd0;
            res_ovf_q    <= 1'b0;
            res_unf_q    <= 1'b0;
            ovf_cnt_q    <= '0;
            unf_cnt_q    <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            id_q         <= id_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_ovf_q    <= res_ovf_d;
            res_unf_q    <= res_unf_d;
            ovf_cnt_q    <= ovf_cnt_d;
            unf_cnt_q    <= unf_cnt_d;
        end
    end

    // The fmul only ever sees captured operands, so requesters may change
    // their inputs freely once accepted.
    assign fm_in1        = op_a_q;
    assign fm_in2        = op_b_q;
    assign res_valid     = res_valid_q;
    assign res_data      = res_data_q;
    assign res_overflow  = res_ovf_q;
    assign res_underflow = res_unf_q;
    assign res_id        = id_q;
    assign ovf_cnt       = ovf_cnt_q;
    assign unf_cnt       = unf_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fmul_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fmul_arbiter
//  Purpose  : Self-checking bench for fmul_arbiter with a simple fmul stand-in
//             and a transaction-level reference model.
//  Revision : 1.0
// ============================================================================
module tb_fmul_arbiter;

    localparam int CNT_W = 8;
    localparam int C_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             req0_valid, req1_valid;
    logic [31:0]      req0_a, req0_b, req1_a, req1_b;
    logic             req0_ready, req1_ready;
    logic             res_valid, res_ready;
    logic [31:0]      res_data;
    logic             res_overflow, res_underflow, res_id;
    logic [31:0]      fm_in1, fm_in2, fm_out;
    logic             fm_overflow, fm_underflow;
    logic [CNT_W-1:0] ovf_cnt, unf_cnt;

    fmul_arbiter #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_overflow(res_overflow), .res_underflow(res_underflow), .res_id(res_id),
        .fm_in1(fm_in1), .fm_in2(fm_in2), .fm_out(fm_out),
        .fm_overflow(fm_overflow), .fm_underflow(fm_underflow),
        .ovf_cnt(ovf_cnt), .unf_cnt(unf_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Truncating single-precision multiply; any denormal operand flushes to zero
    // with underflow flagged. Returns {ovf, unf, product}.
    function automatic logic [33:0] fmul_ref(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          ea, eb, e;
        logic [47:0] p;
        logic [22:0] m;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if (ea == 0 || eb == 0) return {1'b0, (a[30:0] != 0 && b[30:0] != 0), s, 31'd0};
        if (ea == 255 || eb == 255) return {2'b00, s, 8'hFF, 23'd0};
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = ea + eb - 127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 1;
        end else begin
            m = p[45:23];
        end
        if (e >= 255) return {2'b10, s, 8'hFF, 23'd0};
        if (e <= 0) return {2'b01, s, 31'd0};
        return {2'b00, s, e[7:0], m};
    endfunction

    always_comb begin
        {fm_overflow, fm_underflow, fm_out} = fmul_ref(fm_in1, fm_in2);
    end

    int n_vec = 0;
    int n_mis = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction, result visible two
    // cycles after acceptance and held until consumed.
    bit          m_busy = 0;
    int          m_age  = 0;
    bit          m_last = 1;
    bit          m_id   = 0;
    logic [31:0] m_a = 0, m_b = 0;
    logic [33:0] m_exp = 0;
    int          m_ovf = 0, m_unf = 0;
    int          cyc_n = 0;
    int          g_who[$];
    int          g_cyc[$];

    logic        s_r0, s_r1, s_rv, s_ovf, s_unf, s_id;
    logic [31:0] s_data, s_fi1;
    int          s_oc, s_uc;

    task automatic cyc(input logic r, input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                       input logic v1, input logic [31:0] a1, input logic [31:0] b1, input logic rr);
        logic g1, e_r0, e_r1, e_rv;
        rst_n = r; req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1; res_ready = rr;
        @(negedge clk);
        g1   = (v0 && v1) ? !m_last : v1;
        e_r0 = r && !m_busy && v0 && !g1;
        e_r1 = r && !m_busy && v1 && g1;
        e_rv = m_busy && (m_age >= 2);
        s_r0 = req0_ready; s_r1 = req1_ready; s_rv = res_valid; s_data = res_data;
        s_ovf = res_overflow; s_unf = res_underflow; s_id = res_id; s_fi1 = fm_in1;
        s_oc = int'(ovf_cnt); s_uc = int'(unf_cnt);
        check("req0_ready", {31'd0, req0_ready}, {31'd0, e_r0});
        check("req1_ready", {31'd0, req1_ready}, {31'd0, e_r1});
        check("res_valid", {31'd0, res_valid}, {31'd0, e_rv});
        if (e_rv) begin
            check("res_data", res_data, m_exp[31:0]);
            check("res_flags", {30'd0, res_overflow, res_underflow}, {30'd0, m_exp[33:32]});
            check("res_id", {31'd0, res_id}, {31'd0, m_id});
        end
        if (m_busy) begin
            check("fm_in1", fm_in1, m_a);
            check("fm_in2", fm_in2, m_b);
        end
        check("ovf_cnt", {24'd0, ovf_cnt}, m_ovf);
        check("unf_cnt", {24'd0, unf_cnt}, m_unf);
        @(posedge clk);
        if (!r) begin
            m_busy = 0; m_age = 0; m_last = 1; m_ovf = 0; m_unf = 0;
        end else if (!m_busy) begin
            if (e_r0 || e_r1) begin
                m_busy = 1; m_age = 1; m_id = g1; m_last = g1;
                m_a = g1 ? a1 : a0;
                m_b = g1 ? b1 : b0;
                g_who.push_back(int'(g1));
                g_cyc.push_back(cyc_n);
            end
        end else if (m_age == 1) begin
            m_age = 2;
            m_exp = fmul_ref(m_a, m_b);
            if (m_exp[33] && m_ovf < C_MAX) m_ovf++;
            if (m_exp[32] && m_unf < C_MAX) m_unf++;
        end else if (rr) begin
            m_busy = 0;
        end
        cyc_n++;
        #1;
    endtask

    task automatic idle_cyc(input logic rr);
        cyc(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, rr);
    endtask

    task automatic drain();
        for (int i = 0; i < 6 && m_busy; i++) idle_cyc(1'b1);
    endtask

    task automatic one_req(input logic id, input logic [31:0] a, input logic [31:0] b);
        cyc(1'b1, !id, a, b, id, a, b, 1'b1);
        idle_cyc(1'b1);
        idle_cyc(1'b1);
    endtask

    function automatic logic [31:0] pick_op();
        case ($urandom_range(0, 5))
            0: return 32'h7F7FFFFF;
            1: return 32'h00400000;
            2: return 32'h3F800000;
            3: return 32'h00000000;
            default: return $urandom();
        endcase
    endfunction

    typedef struct {
        logic        id;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_data;
        logic        exp_ovf;
        logic        exp_unf;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int          oc0, uc0;
        logic [31:0] hold_data;
        logic        hold_id;
        logic        p0, p1;
        logic [31:0] pa0, pb0, pa1, pb1;

        tbl[0] = '{1'b0, 32'h40400000, 32'h40000000, 32'h40C00000, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 32'h00C00000, 32'h00400000, 32'h00000000, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 32'hC0000000, 32'h40800000, 32'hC1000000, 1'b0, 1'b0};

        rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        repeat (2) @(posedge clk);
        #1;
        // Readies must stay low during reset even with both requesters waiting.
        cyc(1'b0, 1'b1, 32'h1, 32'h2, 1'b1, 32'h3, 32'h4, 1'b1);
        idle_cyc(1'b0);
        check("rst_res_valid", {31'd0, s_rv}, 32'd0);
        check("rst_res_data", s_data, 32'd0);
        check("rst_res_id", {31'd0, s_id}, 32'd0);
        check("rst_fm_in1", s_fi1, 32'd0);
        check("rst_cnts", s_oc + s_uc, 32'd0);

        foreach (tbl[i]) begin
            drain();
            cyc(1'b1, !tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].id, tbl[i].a, tbl[i].b, 1'b1);
            oc0 = s_oc; uc0 = s_uc;
            check("tbl_ready", {30'd0, s_r1, s_r0}, tbl[i].id ? 32'd2 : 32'd1);
            idle_cyc(1'b1);
            check("tbl_calc_no_valid", {31'd0, s_rv}, 32'd0);
            idle_cyc(1'b1);
            check("tbl_res_valid", {31'd0, s_rv}, 32'd1);
            check("tbl_res_data", s_data, tbl[i].exp_data);
            check("tbl_res_flags", {30'd0, s_ovf, s_unf}, {30'd0, tbl[i].exp_ovf, tbl[i].exp_unf});
            check("tbl_res_id", {31'd0, s_id}, {31'd0, tbl[i].id});
            check("tbl_ovf_cnt", s_oc, oc0 + int'(tbl[i].exp_ovf));
            check("tbl_unf_cnt", s_uc, uc0 + int'(tbl[i].exp_unf));
        end

        // Backpressure: result held for five cycles while both requesters wait.
        drain();
        cyc(1'b1, 1'b1, 32'h40400000, 32'h40400000, 1'b0, 32'd0, 32'd0, 1'b0);
        cyc(1'b1, 1'b1, 32'h3F800000, 32'h40000000, 1'b1, 32'h40000000, 32'h40000000, 1'b0);
        cyc(1'b1, 1'b1, 32'h3F800000, 32'h40000000, 1'b1, 32'h40000000, 32'h40000000, 1'b0);
        hold_data = s_data; hold_id = s_id;
        check("bp_first_valid", {31'd0, s_rv}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b1, 32'h3F800000, 32'h40000000, 1'b1, 32'h40000000, 32'h40000000, 1'b0);
            check("bp_stable_data", s_data, hold_data);
            check("bp_stable_id", {31'd0, s_id}, {31'd0, hold_id});
            check("bp_no_ready", {30'd0, s_r1, s_r0}, 32'd0);
        end
        cyc(1'b1, 1'b1, 32'h3F800000, 32'h40000000, 1'b1, 32'h40000000, 32'h40000000, 1'b1);
        cyc(1'b1, 1'b1, 32'h3F800000, 32'h40000000, 1'b1, 32'h40000000, 32'h40000000, 1'b1);
        check("bp_valid_fell", {31'd0, s_rv}, 32'd0);
        check("bp_next_grant_r1", {30'd0, s_r1, s_r0}, 32'd2);
        drain();

        // Reset in CALC discards the in-flight overflowing result.
        cyc(1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b1);
        cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            idle_cyc(1'b1);
            check("rstmid_no_valid", {31'd0, s_rv}, 32'd0);
            check("rstmid_cnts", s_oc + s_uc, 32'd0);
        end

        // Underflow counter saturation.
        for (int i = 0; i < C_MAX + 2; i++) one_req(1'b0, 32'h00C00000, 32'h00400000);
        idle_cyc(1'b1);
        check("unf_saturated", s_uc, C_MAX);

        // Contention from reset: grants alternate 0,1,0,1 three cycles apart.
        cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
        g_who.delete(); g_cyc.delete();
        for (int i = 0; i < 12; i++)
            cyc(1'b1, 1'b1, 32'h40400000, 32'h40000000, 1'b1, 32'h3F800000, 32'h40400000, 1'b1);
        check("rr_grant_count", g_who.size(), 32'd4);
        if (g_who.size() >= 4) begin
            for (int i = 0; i < 4; i++) check("rr_order", g_who[i], i % 2);
            for (int i = 1; i < 4; i++) check("rr_spacing", g_cyc[i] - g_cyc[i-1], 32'd3);
        end
        drain();

        // Randomized traffic with holding requesters, drops and backpressure.
        p0 = 0; p1 = 0; pa0 = 0; pb0 = 0; pa1 = 0; pb1 = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!p0 && $urandom_range(0, 2) == 0) begin p0 = 1; pa0 = pick_op(); pb0 = pick_op(); end
            else if (p0 && $urandom_range(0, 15) == 0) p0 = 0;
            if (!p1 && $urandom_range(0, 2) == 0) begin p1 = 1; pa1 = pick_op(); pb1 = pick_op(); end
            else if (p1 && $urandom_range(0, 15) == 0) p1 = 0;
            cyc(($urandom_range(0, 299) != 0), p0, pa0, pb0, p1, pa1, pb1, ($urandom_range(0, 3) != 0));
            if (s_r0) p0 = 0;
            if (s_r1) p1 = 0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
